gray_code_counter: RTL and testbench

GRAY_CODE_COUNTER -- requirements
Module: gray_code_counter

---
 rtl/gray_code_counter.sv | 61 ++++++
 tb/tb_gray_code_counter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/gray_code_counter.sv
// Up/down binary counter with a registered Gray-code mirror, load, terminal count and wrap pulse.
// Optional build macro GRAY_SATURATE_EN: hold at the terminal value instead of wrapping.
module gray_code_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] step_val;

  assign tc       = up ? (bin_q == '1) : (bin_q == '0);
  assign step_val = up ? (bin_q + ONE) : (bin_q - ONE);

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      wrap_d = tc;
`ifdef GRAY_SATURATE_EN
      if (!tc) bin_d = step_val;
`else
      bin_d = step_val;
`endif
    end
    // Encode from the next binary value so gray and bin update on the same edge.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed self-checking bench for gray_code_counter at WIDTH=4.
module tb_gray_code_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up, load;
  logic [3:0] load_bin, bin, gray;
  logic       tc, wrap;

  int nerr = 0;
  int nchk = 0;

  gray_code_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_bin(load_bin), .bin(bin), .gray(gray), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_bin = 4'h0;
    #2;
    chk("reset_bin", bin, 4'b0000);
    chk("reset_gray", gray, 4'b0000);
    chk("reset_wrap", {3'b0, wrap}, 4'd0);
    chk("reset_tc_up", {3'b0, tc}, 4'd0);
    up = 1'b0;
    #1;
    chk("reset_tc_down", {3'b0, tc}, 4'd1);
  endtask

  task automatic test_count_up();
    step();
    rst_n = 1'b1; en = 1'b1; up = 1'b1;
    repeat (3) step();
    chk("up3_bin", bin, 4'b0011);
    chk("up3_gray", gray, 4'b0010);
    chk("up3_wrap", {3'b0, wrap}, 4'd0);
  endtask

  task automatic test_async_reset();
    repeat (4) step();
    chk("pre_rst_bin", bin, 4'b0111);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_bin", bin, 4'b0000);
    chk("async_rst_gray", gray, 4'b0000);
    chk("async_rst_wrap", {3'b0, wrap}, 4'd0);
    load = 1'b1; load_bin = 4'b1100;
    step();
    chk("rst_ignores_load", bin, 4'b0000);
    rst_n = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    chk("first_step_after_rst", bin, 4'b0001);
  endtask

  task automatic test_load_priority();
    load = 1'b1; load_bin = 4'b1010; en = 1'b1; up = 1'b1;
    step();
    chk("load_bin", bin, 4'b1010);
    chk("load_gray", gray, 4'b1111);
    chk("load_wrap", {3'b0, wrap}, 4'd0);
  endtask

  task automatic test_wrap();
    load = 1'b1; load_bin = 4'b1111;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    chk("ones_gray", gray, 4'b1000);
    chk("ones_tc", {3'b0, tc}, 4'd1);
    step();
`ifdef GRAY_SATURATE_EN
    chk("wrap_bin", bin, 4'b1111);
    chk("wrap_gray", gray, 4'b1000);
`else
    chk("wrap_bin", bin, 4'b0000);
    chk("wrap_gray", gray, 4'b0000);
`endif
    chk("wrap_pulse", {3'b0, wrap}, 4'd1);
    en = 1'b0;
    step();
    chk("wrap_one_cycle", {3'b0, wrap}, 4'd0);
`ifdef GRAY_SATURATE_EN
    chk("hold_bin", bin, 4'b1111);
`else
    chk("hold_bin", bin, 4'b0000);
`endif
  endtask

  task automatic test_down_wrap_reverse();
    load = 1'b1; load_bin = 4'b0000;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    #1;
    chk("zero_tc_down", {3'b0, tc}, 4'd1);
    step();
`ifdef GRAY_SATURATE_EN
    chk("dwrap_bin", bin, 4'b0000);
    chk("dwrap_gray", gray, 4'b0000);
`else
    chk("dwrap_bin", bin, 4'b1111);
    chk("dwrap_gray", gray, 4'b1000);
`endif
    chk("dwrap_pulse", {3'b0, wrap}, 4'd1);
    up = 1'b1;
    step();
`ifdef GRAY_SATURATE_EN
    chk("reverse_bin", bin, 4'b0001);
    chk("reverse_wrap", {3'b0, wrap}, 4'd0);
`else
    chk("reverse_bin", bin, 4'b0000);
    chk("reverse_wrap", {3'b0, wrap}, 4'd1);
`endif
  endtask

  task automatic test_sweep();
    logic [3:0] exp_bin, prev_gray;
    load = 1'b1; load_bin = 4'b0000;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    exp_bin = 4'b0000;
    for (int i = 0; i < 32; i++) begin
      prev_gray = gray;
`ifdef GRAY_SATURATE_EN
      if (exp_bin != 4'b1111) exp_bin = exp_bin + 4'd1;
`else
      exp_bin = exp_bin + 4'd1;
`endif
      step();
      chk("sweep_bin", bin, exp_bin);
      chk("sweep_gray_enc", gray, bin ^ (bin >> 1));
      if (prev_gray != (exp_bin ^ (exp_bin >> 1)))
        chk("sweep_hamming", 4'($countones(prev_gray ^ gray)), 4'd1);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_async_reset();
    test_load_priority();
    test_wrap();
    test_down_wrap_reverse();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
